// File: rtl/jpeg_zz_pkg.sv
// Shared zigzag tables for the JPEG encoder zigzag and decoder inverse-zigzag stages.
package jpeg_zz_pkg;

    localparam int BLK_SZ = 64;
    localparam int IDX_W  = 6;

    // Zigzag scan index k -> raster position (row*8+col).
    localparam logic [IDX_W-1:0] ZZ_TO_RASTER [0:BLK_SZ-1] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    // Raster position -> zigzag scan index (inverse of the table above).
    localparam logic [IDX_W-1:0] RASTER_TO_ZZ [0:BLK_SZ-1] = '{
         0,  1,  5,  6, 14, 15, 27, 28,  2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,  9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54, 20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61, 35, 36, 48, 49, 57, 58, 62, 63
    };

    function automatic logic [IDX_W-1:0] zz_to_raster(input logic [IDX_W-1:0] k);
        return ZZ_TO_RASTER[k];
    endfunction

endpackage

// File: rtl/jpeg_izigzag_bank_ram.sv
// Two-bank coefficient store: one write port, one registered read port, no reset.
module jpeg_izigzag_bank_ram
    import jpeg_zz_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [IDX_W:0]           wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [IDX_W:0]           rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [0:2*BLK_SZ-1];

    // Write port: address is {bank, raster index}.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read port: data register only advances when the output stage loads.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/jpeg_izigzag.sv
// Inverse zigzag reorder: zigzag-ordered coefficients in, raster-ordered out,
// ping-pong buffered so one block fills while the other drains.
module jpeg_izigzag
    import jpeg_zz_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SZ - 1);

    logic [1:0]               bank_full;
    logic [1:0]               bank_full_nxt;
    logic                     wsel;
    logic                     rsel;
    logic [IDX_W-1:0]         wcnt;
    logic [IDX_W-1:0]         rcnt;
    logic                     wr_en;
    logic                     wr_last;
    logic                     ld_p0;
    logic                     ld_last_p0;
    logic                     rel;
    logic signed [DATA_W-1:0] rd_data_p1;

    // Output register loads whenever a full bank exists and the register is free or draining.
    assign ld_p0      = bank_full[rsel] && (!out_valid || out_ready);
    assign ld_last_p0 = ld_p0 && (rcnt == LAST_IDX);
    // Bank under the write pointer frees up this very cycle: lets back-to-back blocks stream.
    assign rel        = ld_last_p0 && (rsel == wsel);
    assign in_ready   = !rst && (!bank_full[wsel] || rel);
    assign wr_en      = in_valid && in_ready;
    assign wr_last    = wr_en && (wcnt == LAST_IDX);

    // Bank flag update: a same-bank clear and set in one cycle resolves to set.
    always_comb begin
        bank_full_nxt = bank_full;
        if (ld_last_p0) bank_full_nxt[rsel] = 1'b0;
        if (wr_last)    bank_full_nxt[wsel] = 1'b1;
    end

    // Write/read pointers and bank flags; partial blocks are dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
        end else begin
            bank_full <= bank_full_nxt;
            if (wr_en) begin
                wcnt <= wcnt + 1'b1;
                if (wr_last) wsel <= !wsel;
            end
            if (ld_p0) begin
                rcnt <= rcnt + 1'b1;
                if (ld_last_p0) rsel <= !rsel;
            end
        end
    end

    // Output valid/last: hold while stalled, drop once accepted with nothing new to load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (ld_p0) begin
            out_valid <= 1'b1;
            out_last  <= (rcnt == LAST_IDX);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    jpeg_izigzag_bank_ram #(
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wsel, zz_to_raster(wcnt)}),
        .wr_data (in_data),
        .rd_en   (ld_p0),
        .rd_addr ({rsel, rcnt}),
        .rd_data (rd_data_p1)
    );

    // ---- stage p1: registered RAM output; zero whenever nothing is presented ----
    assign out_data = out_valid ? rd_data_p1 : '0;

endmodule
